// File: rtl/rtc_hms_counter.sv
// Real-time clock core: prescaler-derived 1 Hz tick driving a seconds/minutes/hours
// carry chain, with run/pause, synchronous time-set load and 12/24-hour display mapping.
module rtc_hms_counter #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_en,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  input  logic       mode_12h,
  output logic [5:0] seconds_out,
  output logic [5:0] minutes_out,
  output logic [4:0] hours_out,
  output logic       pm_out,
  output logic       tick_1hz,
  output logic       day_wrap,
  output logic       set_err
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);

  logic [PRESC_W-1:0] presc;
  logic [5:0]         sec;
  logic [5:0]         min;
  logic [4:0]         hr;

  logic tc;
  logic sec_wrap;
  logic min_wrap;
  logic hr_wrap;
  logic sec_ok;
  logic min_ok;
  logic hr_ok;

  // A load blocks the terminal count, so a load and a carry can never collide.
  assign tc       = run && !set_en && (presc == PRESC_MAX);
  assign sec_wrap = (sec == 6'd59);
  assign min_wrap = (min == 6'd59);
  assign hr_wrap  = (hr == 5'd23);

  assign sec_ok = (set_seconds <= 6'd59);
  assign min_ok = (set_minutes <= 6'd59);
  assign hr_ok  = (set_hours <= 5'd23);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (set_en) begin
      presc <= '0;
    end else if (run) begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec <= 6'd0;
      min <= 6'd0;
      hr  <= 5'd0;
    end else if (set_en) begin
      sec <= sec_ok ? set_seconds : 6'd0;
      min <= min_ok ? set_minutes : 6'd0;
      hr  <= hr_ok  ? set_hours   : 5'd0;
    end else if (tc) begin
      if (sec_wrap) begin
        sec <= 6'd0;
        if (min_wrap) begin
          min <= 6'd0;
          hr  <= hr_wrap ? 5'd0 : hr + 5'd1;
        end else begin
          min <= min + 6'd1;
        end
      end else begin
        sec <= sec + 6'd1;
      end
    end
  end

  // Pulses are registered so they line up with the updated time registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_1hz <= 1'b0;
      day_wrap <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      tick_1hz <= tc;
      day_wrap <= tc && sec_wrap && min_wrap && hr_wrap;
      set_err  <= set_en && !(sec_ok && min_ok && hr_ok);
    end
  end

  always_comb begin
    hours_out = hr;
    if (mode_12h) begin
      if (hr == 5'd0) begin
        hours_out = 5'd12;
      end else if (hr > 5'd12) begin
        hours_out = hr - 5'd12;
      end
    end
  end

  assign pm_out      = (hr >= 5'd12);
  assign seconds_out = sec;
  assign minutes_out = min;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Directed self-checking bench for rtc_hms_counter with a 4-cycle second.
module tb_rtc_hms_counter;

  logic       clk;
  logic       reset;
  logic       run;
  logic       set_en;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic       mode_12h;
  logic [5:0] seconds_out;
  logic [5:0] minutes_out;
  logic [4:0] hours_out;
  logic       pm_out;
  logic       tick_1hz;
  logic       day_wrap;
  logic       set_err;

  int checks;
  int failures;

  rtc_hms_counter #(.CLK_FREQ_HZ(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .set_en      (set_en),
    .set_hours   (set_hours),
    .set_minutes (set_minutes),
    .set_seconds (set_seconds),
    .mode_12h    (mode_12h),
    .seconds_out (seconds_out),
    .minutes_out (minutes_out),
    .hours_out   (hours_out),
    .pm_out      (pm_out),
    .tick_1hz    (tick_1hz),
    .day_wrap    (day_wrap),
    .set_err     (set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_hours   = h;
    set_minutes = m;
    set_seconds = s;
    set_en      = 1'b1;
    cycle();
    set_en      = 1'b0;
  endtask

  task automatic checkTime(input string tag, input int h, input int m, input int s);
    checkOutput({tag, "_hr"}, 32'(hours_out), h);
    checkOutput({tag, "_min"}, 32'(minutes_out), m);
    checkOutput({tag, "_sec"}, 32'(seconds_out), s);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    run         = 1'b0;
    set_en      = 1'b0;
    set_hours   = '0;
    set_minutes = '0;
    set_seconds = '0;
    mode_12h    = 1'b0;

    repeat (2) cycle();
    checkTime("rst", 0, 0, 0);
    checkOutput("rst_pm", 32'(pm_out), 0);
    checkOutput("rst_tick", 32'(tick_1hz), 0);
    checkOutput("rst_wrap", 32'(day_wrap), 0);
    checkOutput("rst_err", 32'(set_err), 0);
    mode_12h = 1'b1;
    #1;
    checkOutput("rst_hr12", 32'(hours_out), 12);
    mode_12h = 1'b0;

    // Free-run 60 seconds from reset: one tick every 4 cycles.
    reset = 1'b1;
    run   = 1'b1;
    for (int t = 0; t < 60; t++) begin
      for (int c = 0; c < 3; c++) begin
        cycle();
        checkOutput("run_tick_low", 32'(tick_1hz), 0);
        checkOutput("run_wrap_low", 32'(day_wrap), 0);
      end
      cycle();
      checkOutput("run_tick_high", 32'(tick_1hz), 1);
      checkOutput("run_wrap", 32'(day_wrap), 0);
      checkOutput("run_sec", 32'(seconds_out), (t + 1) % 60);
      checkOutput("run_min", 32'(minutes_out), (t + 1) / 60);
    end
    checkTime("after60", 0, 1, 0);

    // Day rollover from 23:59:58.
    applyStimulus(5'd23, 6'd59, 6'd58);
    checkTime("load_2359", 23, 59, 58);
    checkOutput("load_tick", 32'(tick_1hz), 0);
    checkOutput("load_err", 32'(set_err), 0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      checkOutput("dw_tick_low1", 32'(tick_1hz), 0);
    end
    cycle();
    checkOutput("dw_tick1", 32'(tick_1hz), 1);
    checkOutput("dw_wrap1", 32'(day_wrap), 0);
    checkTime("dw_t1", 23, 59, 59);
    for (int c = 0; c < 3; c++) begin
      cycle();
      checkOutput("dw_tick_low2", 32'(tick_1hz), 0);
      checkOutput("dw_wrap_low2", 32'(day_wrap), 0);
    end
    cycle();
    checkOutput("dw_tick2", 32'(tick_1hz), 1);
    checkOutput("dw_wrap2", 32'(day_wrap), 1);
    checkTime("dw_t2", 0, 0, 0);
    checkOutput("dw_pm", 32'(pm_out), 0);
    cycle();
    checkOutput("dw_wrap_after", 32'(day_wrap), 0);
    checkOutput("dw_tick_after", 32'(tick_1hz), 0);

    // 12/24-hour mapping with the clock paused.
    run = 1'b0;
    mode_12h = 1'b1;
    applyStimulus(5'd0, 6'd0, 6'd0);
    checkOutput("h0_12h", 32'(hours_out), 12);
    checkOutput("h0_pm", 32'(pm_out), 0);
    mode_12h = 1'b0;
    #1;
    checkOutput("h0_24h", 32'(hours_out), 0);
    mode_12h = 1'b1;
    applyStimulus(5'd13, 6'd0, 6'd0);
    checkOutput("h13_12h", 32'(hours_out), 1);
    checkOutput("h13_pm", 32'(pm_out), 1);
    mode_12h = 1'b0;
    #1;
    checkOutput("h13_24h", 32'(hours_out), 13);
    checkOutput("h13_pm24", 32'(pm_out), 1);
    mode_12h = 1'b1;
    applyStimulus(5'd12, 6'd0, 6'd0);
    checkOutput("h12_12h", 32'(hours_out), 12);
    checkOutput("h12_pm", 32'(pm_out), 1);
    mode_12h = 1'b0;
    #1;
    checkOutput("h12_24h", 32'(hours_out), 12);
    mode_12h = 1'b1;
    applyStimulus(5'd11, 6'd0, 6'd0);
    checkOutput("h11_12h", 32'(hours_out), 11);
    checkOutput("h11_pm", 32'(pm_out), 0);
    mode_12h = 1'b0;

    // Out-of-range fields load as zero individually and flag set_err.
    applyStimulus(5'd24, 6'd30, 6'd61);
    checkTime("bad_load", 0, 30, 0);
    checkOutput("bad_err", 32'(set_err), 1);
    cycle();
    checkOutput("bad_err_clear", 32'(set_err), 0);
    applyStimulus(5'd10, 6'd60, 6'd20);
    checkTime("bad_min", 10, 0, 20);
    checkOutput("bad_min_err", 32'(set_err), 1);
    applyStimulus(5'd5, 6'd6, 6'd7);
    checkTime("good_load", 5, 6, 7);
    checkOutput("good_err", 32'(set_err), 0);

    // Pause mid-second: prescaler count survives the pause.
    run = 1'b1;
    applyStimulus(5'd12, 6'd34, 6'd56);
    repeat (2) cycle();
    run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      checkOutput("pause_tick", 32'(tick_1hz), 0);
      checkOutput("pause_sec", 32'(seconds_out), 56);
    end
    run = 1'b1;
    cycle();
    checkOutput("resume_tick_low", 32'(tick_1hz), 0);
    cycle();
    checkOutput("resume_tick", 32'(tick_1hz), 1);
    checkTime("resume", 12, 34, 57);

    // Asynchronous reset mid-second.
    applyStimulus(5'd12, 6'd34, 6'd56);
    repeat (2) cycle();
    #2;
    reset = 1'b0;
    #1;
    checkTime("areset", 0, 0, 0);
    checkOutput("areset_pm", 32'(pm_out), 0);
    cycle();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checkOutput("post_rst_tick_low", 32'(tick_1hz), 0);
    end
    cycle();
    checkOutput("post_rst_tick", 32'(tick_1hz), 1);
    checkOutput("post_rst_sec", 32'(seconds_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_hms_counter.md
Name: rtc_hms_counter

Overview:
Parametrised real-time clock core that extends the seconds/minutes timekeeper with an hours counter, 12/24-hour display mode, run/pause control and synchronous time-set load. It contains an internal prescaler (time base) that produces a 1 Hz tick from the system clock, followed by a seconds→minutes→hours carry chain. Outputs drive display/decoder logic directly.

Parameters:
CLK_FREQ_HZ, 50000000, system clock cycles per second tick; legal range ≥2 (benches use 4).
PRESC_W, $clog2(CLK_FREQ_HZ), prescaler counter width; derived, not overridden.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
run  in  1  1 = prescaler advances; 0 = time frozen, prescaler holds
set_en  in  1  1 = load set_* values this cycle (overrides counting)
set_hours  in  5  load value for hours, 24h format 0..23
set_minutes  in  6  load value for minutes 0..59
set_seconds  in  6  load value for seconds 0..59
mode_12h  in  1  1 = hours_out in 12h format, 0 = 24h format
seconds_out  out  6  current seconds 0..59
minutes_out  out  6  current minutes 0..59
hours_out  out  5  current hours (0..23 in 24h; 1..12 in 12h)
pm_out  out  1  1 when internal hour ≥12 (valid in both modes)
tick_1hz  out  1  one-cycle pulse per second advance
day_wrap  out  1  one-cycle pulse on 23:59:59→00:00:00
set_err  out  1  one-cycle pulse when a set_en load contained an out-of-range field

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0, seconds=0, minutes=0, hours=0, tick_1hz=0, day_wrap=0, set_err=0. Outputs: seconds_out=0, minutes_out=0, hours_out=0 (24h) or 12 (12h), pm_out=0. Reset deassertion is taken synchronously on the next clk edge; no counting in the deassertion cycle.
- Internal state: prescaler (PRESC_W bits), sec (6), min (6), hr (5, always 24h form 0..23). All registered.
- Prescaler: when run=1 and set_en=0: if prescaler==CLK_FREQ_HZ-1 then prescaler←0 and tc=1, else prescaler+1. When run=0: prescaler holds, tc=0.
- On tc (same edge the prescaler wraps): sec increments; sec 59→0 carries to min; min 59→0 carries to hr; hr 23→0. tick_1hz=1 for that one cycle (registered, aligned with the new sec value). day_wrap=1 for that one cycle only on 23:59:59→00:00:00.
- First tick after reset or after a load occurs exactly CLK_FREQ_HZ run-enabled cycles later.
- Set (set_en=1, highest priority after reset, independent of run): sec←set_seconds, min←set_minutes, hr←set_hours, prescaler←0, tick_1hz=0, day_wrap=0. Any field out of range (sec>59, min>59, hr>23) is loaded as 0 for that field only; set_err=1 for one cycle. set_en held high reloads every cycle; counting resumes the first cycle after set_en falls.
- Display mapping (combinational from registers, zero added latency): 24h: hours_out=hr. 12h: hr=0→12, 1..12→hr, 13..23→hr-12. pm_out=(hr≥12) in both modes. mode_12h may change any cycle; only the output mapping changes, never the stored time.
- seconds_out=sec, minutes_out=min directly.
- Simultaneous tc and set_en: impossible by construction (set_en blocks tc); the load wins.
- run falling mid-second: prescaler count preserved; resumes from same value when run returns to 1.
- Out-of-range internal values are unreachable; no recovery logic beyond reset/load required.

Test Plan:
- CLK_FREQ_HZ=4, reset low then high, run=1: tick_1hz pulses every 4 cycles; after 60 ticks seconds_out=0, minutes_out=1; no day_wrap.
- set_en for one cycle with 23:59:58, run=1: two ticks later outputs 00:00:00, day_wrap=1 for exactly one cycle coinciding with the 2nd tick_1hz.
- Load hr=0, then hr=13, then hr=12, each with mode_12h=1: hours_out=12/pm_out=0, hours_out=1/pm_out=1, hours_out=12/pm_out=1; mode_12h=0 shows 0,13,12.
- Load set_hours=24, set_minutes=30, set_seconds=61: stored time 00:30:00, set_err=1 one cycle; valid load gives set_err=0.
- run=1 for 2 cycles, run=0 for 10 cycles, run=1: next tick_1hz exactly 2 run cycles later; time unchanged while paused.
- Assert reset asynchronously mid-second at 12:34:56: outputs go to 0 without waiting for clk edge; first tick 4 cycles after release.
